fft_stream_bridge: RTL and testbench
====================================

# fft_stream_bridge

Parametrised Wishbone-to-AXI-Stream bridge around an external streaming FFT core, successor to the fixed 64-point OFDM FFT wrapper. It accepts time-domain samples as a Wishbone pipeline slave and frames them into FFT_N-point blocks with generated TLAST. It loads a runtime scaling schedule into the core at frame boundaries, tracks frames in flight with input backpressure, and narrows and re-emits the core output as a Wishbone pipeline master with a bin index. It sits between the CP-removal stage and the equaliser in the receive PHY.

## Interface
- DW, 16: per-component bus sample width; bus word is {Im, Re}, 2*DW bits.
- CW, 24: per-component core output width; CW >= DW.
- LOG2N, 6: FFT length exponent; FFT_N = 2^LOG2N.
- OUT_SHIFT, 0: arithmetic right shift applied to core output before narrowing.
- FRM_MAX, 4: maximum number of frames in flight.
- CFG_RST, 16'h0003: scaling/config word loaded after reset.
- CLK_I  in  1  clock.
- RSTN_I  in  1  reset; asynchronous, active-low.
- DAT_I  in  2*DW  input sample {Im, Re}.
- WE_I, STB_I, CYC_I  in  1  Wishbone slave qualifiers.
- ACK_O  out  1  input beat accepted (combinational).
- DAT_O  out  2*DW  output bin {Im, Re}.
- IDX_O  out  LOG2N  bin index of DAT_O.
- CYC_O, STB_O, WE_O  out  1  Wishbone master qualifiers; WE_O = STB_O.
- ACK_I  in  1  downstream accept.
- CFG_I  in  16  new config word.
- CFG_WE_I  in  1  config write strobe.
- CORE_CFG_TDATA  out  16; CORE_CFG_TVALID  out  1; CORE_CFG_TREADY  in  1.
- CORE_S_TDATA  out  2*DW; CORE_S_TVALID  out  1; CORE_S_TREADY  in  1; CORE_S_TLAST  out  1.
- CORE_M_TDATA  in  2*CW; CORE_M_TVALID  in  1; CORE_M_TLAST  in  1; CORE_M_TREADY  out  1.
- FRM_CNT_O  out  $clog2(FRM_MAX+1)  frames in flight.
- ERR_O  out  1  sticky output TLAST mismatch.

## Operation
- Input valid: `s_val = CYC_I & STB_I & WE_I`.
  - Input stalls when `cfg_block` (`CORE_CFG_TVALID`) is high or FRM_CNT_O == FRM_MAX.
  - `CORE_S_TVALID = s_val & ~stall`; `ACK_O = CORE_S_TVALID & CORE_S_TREADY`; `CORE_S_TDATA = DAT_I`.
- in_cnt (LOG2N bits): increments on each input handshake, wrapping N-1 -> 0. `CORE_S_TLAST = (in_cnt == N-1)`.
- Config: registers `shadow`, `pend`, `CORE_CFG_TDATA`.
  - CFG_WE_I: `shadow <= CFG_I`, `pend <= 1`.
  - When pend, in_cnt == 0 and CORE_CFG_TVALID is low, the next edge sets `CORE_CFG_TDATA <= shadow`, `CORE_CFG_TVALID <= 1`, `pend <= 0`.
  - CORE_CFG_TVALID clears on TREADY. TDATA is stable while TVALID is high.
  - A CFG_WE_I arriving during SEND re-arms pend, so the new word is sent at the next frame boundary. A word is never applied mid-frame.
- Frame counter: +1 on an input handshake with TLAST, -1 on an output load with CORE_M_TLAST. Both in the same cycle: unchanged.
- Output:
  - `out_rdy = ~STB_O | ACK_I`; `CORE_M_TREADY = out_rdy`.
  - On `out_rdy & CORE_M_TVALID`: load DAT_O = conv(core), IDX_O = out_cnt, STB_O = 1, and increment out_cnt (wraps).
  - On `out_rdy & ~CORE_M_TVALID`: STB_O = 0.
- ERR_O sets when a loaded beat has `CORE_M_TLAST != (out_cnt == N-1)`. It clears only on reset.
- CYC_O:
  - Set on any output load.
  - Cleared when the next STB_O is 0, FRM_CNT_O is 0 (post-update) and CYC_I is low.
- conv, per component, with Im in [2*CW-1:CW] and Re in [CW-1:0]: signed value >>> OUT_SHIFT, then narrowed to DW bits (see Configuration).

## Timing
- Reset values:
  - STB_O, CYC_O, ERR_O, CORE_CFG_TVALID: 0.
  - DAT_O, IDX_O, in_cnt, out_cnt, FRM_CNT_O: 0.
  - shadow: CFG_RST; pend: 1, so the first config is sent on the first edge after reset.
- Input path is combinational (ACK_O same cycle). Output path has one register stage, core beat to STB_O.
- Back-to-back throughput is 1 beat/clock each direction with ACK_I held high.
- Reset mid-frame discards partial frames and counters; the core must be reset alongside.

## Configuration
- FFTB_SAT_EN defined: narrowing saturates to [-2^(DW-1), 2^(DW-1)-1].
- FFTB_SAT_EN undefined: narrowing keeps the low DW bits (wraps).

## Test plan
- Reset release with core CFG_TREADY=1 -> CORE_CFG_TVALID high for exactly 1 cycle with TDATA 16'h0003, input stalled that cycle.
- 64 consecutive input beats with TREADY=1 -> ACK_O 64 cycles, CORE_S_TLAST only on beat 64, FRM_CNT_O = 1 afterwards.
- CFG_WE_I=16'h006F at in_cnt=10 -> config sent only once in_cnt returns to 0; no ACK_O in that cycle.
- Core output 64 beats with ACK_I toggling 1/0 -> no beat lost or duplicated, IDX_O 0..63, CYC_O drops after last ACK_I with FRM_CNT_O = 0.
- Core Re = 24'sh7FFFFF, DW=16, OUT_SHIFT=0 -> DAT_O[15:0] = 16'h7FFF with FFTB_SAT_EN, 16'hFFFF without.
- Core TLAST asserted at out_cnt=31 -> ERR_O = 1 and stays 1 until RSTN_I low; FRM_MAX frames pending -> ACK_O held 0.

Source files
------------

// File: rtl/fft_stream_bridge.sv
// fft_stream_bridge: Wishbone pipeline slave -> AXI-Stream FFT core -> Wishbone
// pipeline master. Frames input samples into FFT_N-point blocks with TLAST, loads
// the core scaling schedule at frame boundaries, limits frames in flight and
// re-emits narrowed core output with a bin index.
// Optional feature macro: FFTB_SAT_EN (saturating narrowing; default wraps).
module fft_stream_bridge #(
    parameter int          DW        = 16,
    parameter int          CW        = 24,
    parameter int          LOG2N     = 6,
    parameter int          OUT_SHIFT = 0,
    parameter int          FRM_MAX   = 4,
    parameter logic [15:0] CFG_RST   = 16'h0003
) (
    input  logic                             CLK_I,
    input  logic                             RSTN_I,
    input  logic [2*DW-1:0]                  DAT_I,
    input  logic                             WE_I,
    input  logic                             STB_I,
    input  logic                             CYC_I,
    output logic                             ACK_O,
    output logic [2*DW-1:0]                  DAT_O,
    output logic [LOG2N-1:0]                 IDX_O,
    output logic                             CYC_O,
    output logic                             STB_O,
    output logic                             WE_O,
    input  logic                             ACK_I,
    input  logic [15:0]                      CFG_I,
    input  logic                             CFG_WE_I,
    output logic [15:0]                      CORE_CFG_TDATA,
    output logic                             CORE_CFG_TVALID,
    input  logic                             CORE_CFG_TREADY,
    output logic [2*DW-1:0]                  CORE_S_TDATA,
    output logic                             CORE_S_TVALID,
    input  logic                             CORE_S_TREADY,
    output logic                             CORE_S_TLAST,
    input  logic [2*CW-1:0]                  CORE_M_TDATA,
    input  logic                             CORE_M_TVALID,
    input  logic                             CORE_M_TLAST,
    output logic                             CORE_M_TREADY,
    output logic [$clog2(FRM_MAX+1)-1:0]     FRM_CNT_O,
    output logic                             ERR_O
);

    localparam int FW = $clog2(FRM_MAX+1);
    localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
    localparam logic [FW-1:0]    FRM_FULL = FW'(FRM_MAX);
    localparam logic [FW-1:0]    FRM_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0]    FRM_ONE  = {{(FW-1){1'b0}}, 1'b1};

`ifdef FFTB_SAT_EN
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    // Scale one core component and narrow it to the bus width.
    function automatic logic [DW-1:0] narrow(input logic signed [CW-1:0] v);
        logic signed [CW-1:0] s;
        s = v >>> OUT_SHIFT;
`ifdef FFTB_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return s[DW-1:0];
        end
`else
        return s[DW-1:0];
`endif
    endfunction

    logic [LOG2N-1:0] r_in_cnt;
    logic [LOG2N-1:0] r_out_cnt;
    logic [FW-1:0]    r_frm_cnt;
    logic [15:0]      r_shadow;
    logic             r_pend;
    logic [15:0]      r_cfg_tdata;
    logic             r_cfg_tvalid;
    logic [2*DW-1:0]  r_dat;
    logic [LOG2N-1:0] r_idx;
    logic             r_stb;
    logic             r_cyc;
    logic             r_err;

    logic             w_s_val;
    logic             w_stall;
    logic             w_s_tvalid;
    logic             w_in_hs;
    logic             w_s_tlast;
    logic             w_cfg_load;
    logic             w_out_rdy;
    logic             w_out_load;
    logic             w_frm_inc;
    logic             w_frm_dec;
    logic [FW-1:0]    w_frm_nxt;
    logic             w_stb_nxt;
    logic [2*DW-1:0]  w_dat_conv;

    // Input qualification, stall and handshake; config load trigger.
    always_comb begin
        w_s_val    = CYC_I & STB_I & WE_I;
        w_stall    = r_cfg_tvalid | (r_frm_cnt == FRM_FULL);
        w_s_tvalid = w_s_val & ~w_stall;
        w_in_hs    = w_s_tvalid & CORE_S_TREADY;
        w_s_tlast  = (r_in_cnt == LAST_IDX);
        w_cfg_load = r_pend & (r_in_cnt == {LOG2N{1'b0}}) & ~r_cfg_tvalid;
    end

    // Output pipeline control, frame counter next value and data conversion.
    always_comb begin
        w_out_rdy  = ~r_stb | ACK_I;
        w_out_load = w_out_rdy & CORE_M_TVALID;
        w_frm_inc  = w_in_hs & w_s_tlast;
        w_frm_dec  = w_out_load & CORE_M_TLAST;
        w_frm_nxt  = r_frm_cnt;
        if (w_frm_inc && !w_frm_dec) begin
            w_frm_nxt = r_frm_cnt + FRM_ONE;
        end else if (w_frm_dec && !w_frm_inc && (r_frm_cnt != FRM_ZERO)) begin
            // A TLAST with nothing in flight is a core fault; never wrap below zero.
            w_frm_nxt = r_frm_cnt - FRM_ONE;
        end else begin
            w_frm_nxt = r_frm_cnt;
        end
        if (w_out_load) begin
            w_stb_nxt = 1'b1;
        end else if (w_out_rdy) begin
            w_stb_nxt = 1'b0;
        end else begin
            w_stb_nxt = r_stb;
        end
        w_dat_conv = {narrow(CORE_M_TDATA[2*CW-1:CW]), narrow(CORE_M_TDATA[CW-1:0])};
    end

    // Input beat counter that frames the stream into FFT_N-point blocks.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_in_cnt <= {LOG2N{1'b0}};
        end else if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + {{(LOG2N-1){1'b0}}, 1'b1};
        end
    end

    // Config shadow/pending state and the core config channel, applied only at frame boundaries.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_shadow     <= CFG_RST;
            r_pend       <= 1'b1;
            r_cfg_tdata  <= 16'h0000;
            r_cfg_tvalid <= 1'b0;
        end else begin
            if (CFG_WE_I) begin
                r_shadow <= CFG_I;
            end
            // A new write during a send re-arms pend so it goes at the next boundary.
            if (CFG_WE_I) begin
                r_pend <= 1'b1;
            end else if (w_cfg_load) begin
                r_pend <= 1'b0;
            end
            if (w_cfg_load) begin
                r_cfg_tdata  <= r_shadow;
                r_cfg_tvalid <= 1'b1;
            end else if (r_cfg_tvalid && CORE_CFG_TREADY) begin
                r_cfg_tvalid <= 1'b0;
            end
        end
    end

    // Frames-in-flight counter.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_frm_cnt <= FRM_ZERO;
        end else begin
            r_frm_cnt <= w_frm_nxt;
        end
    end

    // Output register stage, bin index counter and TLAST consistency flag.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_dat     <= {(2*DW){1'b0}};
            r_idx     <= {LOG2N{1'b0}};
            r_out_cnt <= {LOG2N{1'b0}};
            r_stb     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_stb <= w_stb_nxt;
            if (w_out_load) begin
                r_dat     <= w_dat_conv;
                r_idx     <= r_out_cnt;
                r_out_cnt <= r_out_cnt + {{(LOG2N-1){1'b0}}, 1'b1};
                if (CORE_M_TLAST != (r_out_cnt == LAST_IDX)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Output bus cycle: held while data or frames are pending or upstream is active.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_cyc <= 1'b0;
        end else if (w_out_load) begin
            r_cyc <= 1'b1;
        end else if (!w_stb_nxt && (w_frm_nxt == FRM_ZERO) && !CYC_I) begin
            r_cyc <= 1'b0;
        end
    end

    assign CORE_S_TVALID   = w_s_tvalid;
    assign CORE_S_TDATA    = DAT_I;
    assign CORE_S_TLAST    = w_s_tlast;
    assign ACK_O           = w_in_hs;
    assign CORE_CFG_TDATA  = r_cfg_tdata;
    assign CORE_CFG_TVALID = r_cfg_tvalid;
    assign CORE_M_TREADY   = w_out_rdy;
    assign DAT_O           = r_dat;
    assign IDX_O           = r_idx;
    assign STB_O           = r_stb;
    assign WE_O            = r_stb;
    assign CYC_O           = r_cyc;
    assign FRM_CNT_O       = r_frm_cnt;
    assign ERR_O           = r_err;

endmodule

// File: tb/tb_fft_stream_bridge.sv
// Self-checking bench for fft_stream_bridge (default parameters).
module tb_fft_stream_bridge;

    localparam int DW = 16;
    localparam int CW = 24;
    localparam int LOG2N = 6;
    localparam int OUT_SHIFT = 0;

    logic          CLK_I = 1'b0;
    logic          RSTN_I;
    logic [31:0]   DAT_I;
    logic          WE_I, STB_I, CYC_I;
    logic          ACK_O;
    logic [31:0]   DAT_O;
    logic [5:0]    IDX_O;
    logic          CYC_O, STB_O, WE_O;
    logic          ACK_I;
    logic [15:0]   CFG_I;
    logic          CFG_WE_I;
    logic [15:0]   CORE_CFG_TDATA;
    logic          CORE_CFG_TVALID;
    logic          CORE_CFG_TREADY;
    logic [31:0]   CORE_S_TDATA;
    logic          CORE_S_TVALID;
    logic          CORE_S_TREADY;
    logic          CORE_S_TLAST;
    logic [47:0]   CORE_M_TDATA;
    logic          CORE_M_TVALID;
    logic          CORE_M_TLAST;
    logic          CORE_M_TREADY;
    logic [2:0]    FRM_CNT_O;
    logic          ERR_O;

    fft_stream_bridge dut (
        .CLK_I(CLK_I), .RSTN_I(RSTN_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
        .CYC_I(CYC_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .IDX_O(IDX_O), .CYC_O(CYC_O),
        .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .CFG_I(CFG_I), .CFG_WE_I(CFG_WE_I),
        .CORE_CFG_TDATA(CORE_CFG_TDATA), .CORE_CFG_TVALID(CORE_CFG_TVALID),
        .CORE_CFG_TREADY(CORE_CFG_TREADY), .CORE_S_TDATA(CORE_S_TDATA),
        .CORE_S_TVALID(CORE_S_TVALID), .CORE_S_TREADY(CORE_S_TREADY),
        .CORE_S_TLAST(CORE_S_TLAST), .CORE_M_TDATA(CORE_M_TDATA),
        .CORE_M_TVALID(CORE_M_TVALID), .CORE_M_TLAST(CORE_M_TLAST),
        .CORE_M_TREADY(CORE_M_TREADY), .FRM_CNT_O(FRM_CNT_O), .ERR_O(ERR_O)
    );

    // Free-running clock.
    always #5 CLK_I = ~CLK_I;

    int n_total = 0;
    int n_bad   = 0;
    int m_in_cnt = 0;
    logic [37:0] sb_q[$];

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing of one 24-bit core component.
    function automatic logic [15:0] exp_narrow(input logic [23:0] v);
        logic signed [31:0] sv;
        sv = 32'($signed(v));
        sv = sv >>> OUT_SHIFT;
`ifdef FFTB_SAT_EN
        if (sv > 32'sd32767) return 16'h7FFF;
        else if (sv < -32'sd32768) return 16'h8000;
        else return sv[15:0];
`else
        return sv[15:0];
`endif
    endfunction

    function automatic logic [23:0] gen_re(input int b);
        if (b == 5) return 24'h7FFFFF;
        else if (b == 6) return 24'h800000;
        else return 24'(b * 7 - 200);
    endfunction

    function automatic logic [23:0] gen_im(input int f, input int b);
        if (b == 7) return 24'h012345;
        else return 24'(f * 1000 - b * 50);
    endfunction

    // Stream n input beats; entered and left just after a rising edge.
    task automatic send_beats(input int n);
        int acks = 0;
        int cyc = 0;
        while (acks < n && cyc < n + 20) begin
            CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
            DAT_I = $urandom;
            @(negedge CLK_I);
            chk_val("cfg_idle", CORE_CFG_TVALID, 1'b0);
            if (ACK_O) begin
                chk_val("s_tdata", CORE_S_TDATA, DAT_I);
                chk_val("s_tlast", CORE_S_TLAST, (m_in_cnt == 63));
                m_in_cnt = (m_in_cnt + 1) % 64;
                acks++;
            end
            cyc++;
            @(posedge CLK_I); #1;
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        chk_val("ack_run", cyc, n);
    endtask

    initial begin
        int k, popped, total, ackt;
        logic [37:0] e;
        RSTN_I = 1'b0;
        DAT_I = 32'h0; WE_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0;
        ACK_I = 1'b0; CFG_I = 16'h0; CFG_WE_I = 1'b0;
        CORE_CFG_TREADY = 1'b1; CORE_S_TREADY = 1'b1;
        CORE_M_TDATA = 48'h0; CORE_M_TVALID = 1'b0; CORE_M_TLAST = 1'b0;

        // Reset state.
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        chk_val("rst_stb", STB_O, 1'b0);
        chk_val("rst_cyc", CYC_O, 1'b0);
        chk_val("rst_err", ERR_O, 1'b0);
        chk_val("rst_cfgv", CORE_CFG_TVALID, 1'b0);
        chk_val("rst_dat", DAT_O, 32'h0);
        chk_val("rst_idx", IDX_O, 6'h0);
        chk_val("rst_frm", FRM_CNT_O, 3'h0);
        RSTN_I = 1'b1;

        // First config word goes out on the first edge; input stalled meanwhile.
        @(posedge CLK_I); #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        @(negedge CLK_I);
        chk_val("cfg0_v", CORE_CFG_TVALID, 1'b1);
        chk_val("cfg0_d", CORE_CFG_TDATA, 16'h0003);
        chk_val("cfg0_ack", ACK_O, 1'b0);
        chk_val("cfg0_stv", CORE_S_TVALID, 1'b0);
        @(posedge CLK_I); #1;

        // Frame 1: 64 consecutive beats.
        send_beats(64);
        @(negedge CLK_I);
        chk_val("frm1", FRM_CNT_O, 3'd1);
        @(posedge CLK_I); #1;

        // Config write mid-frame is deferred to the frame boundary.
        send_beats(10);
        CFG_I = 16'h006F; CFG_WE_I = 1'b1;
        @(posedge CLK_I); #1;
        CFG_WE_I = 1'b0;
        send_beats(54);
        @(posedge CLK_I); #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        @(negedge CLK_I);
        chk_val("cfg1_v", CORE_CFG_TVALID, 1'b1);
        chk_val("cfg1_d", CORE_CFG_TDATA, 16'h006F);
        chk_val("cfg1_ack", ACK_O, 1'b0);
        @(posedge CLK_I); #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(negedge CLK_I);
        chk_val("cfg1_clr", CORE_CFG_TVALID, 1'b0);
        chk_val("frm2", FRM_CNT_O, 3'd2);
        @(posedge CLK_I); #1;

        // Fill to FRM_MAX frames, then input must stall.
        send_beats(128);
        for (int i = 0; i < 4; i++) begin
            CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
            @(negedge CLK_I);
            chk_val("full_ack", ACK_O, 1'b0);
            chk_val("full_frm", FRM_CNT_O, 3'd4);
            @(posedge CLK_I); #1;
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;

        // Core output: 3 good frames then a frame with TLAST at beat 31.
        total = 64 * 3 + 32;
        k = 0; popped = 0; ackt = 1;
        for (int cyc = 0; cyc < 2000 && popped < total; cyc++) begin
            if (k < total) begin
                CORE_M_TVALID = 1'b1;
                CORE_M_TDATA  = {gen_im(k / 64, k % 64), gen_re(k % 64)};
                CORE_M_TLAST  = (k < 192) ? ((k % 64) == 63) : (k == total - 1);
            end else begin
                CORE_M_TVALID = 1'b0;
                CORE_M_TLAST  = 1'b0;
            end
            ACK_I = ackt[0];
            ackt  = ackt ^ 1;
            @(negedge CLK_I);
            if (STB_O && ACK_I) begin
                if (sb_q.size() == 0) begin
                    chk_val("sb_empty", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk_val("out_dat", DAT_O, e[31:0]);
                    chk_val("out_idx", IDX_O, e[37:32]);
                    chk_val("out_cyc", CYC_O, 1'b1);
                    chk_val("out_err", ERR_O, (popped == total - 1));
                    if (popped == 5) begin
`ifdef FFTB_SAT_EN
                        chk_val("sat_re", DAT_O[15:0], 16'h7FFF);
`else
                        chk_val("sat_re", DAT_O[15:0], 16'hFFFF);
`endif
                    end
                end
                popped++;
            end
            if (CORE_M_TVALID && CORE_M_TREADY) begin
                sb_q.push_back({6'(k % 64),
                                exp_narrow(gen_im(k / 64, k % 64)),
                                exp_narrow(gen_re(k % 64))});
                k++;
            end
            @(posedge CLK_I); #1;
        end
        chk_val("out_count", popped, total);
        chk_val("sb_left", sb_q.size(), 0);
        CORE_M_TVALID = 1'b0; CORE_M_TLAST = 1'b0; ACK_I = 1'b1;
        @(negedge CLK_I);
        chk_val("cyc_drop", CYC_O, 1'b0);
        chk_val("stb_drop", STB_O, 1'b0);
        chk_val("frm_zero", FRM_CNT_O, 3'd0);
        repeat (5) @(posedge CLK_I);
        @(negedge CLK_I);
        chk_val("err_sticky", ERR_O, 1'b1);

        // Reset clears the sticky error.
        RSTN_I = 1'b0;
        #2;
        chk_val("rst2_err", ERR_O, 1'b0);
        chk_val("rst2_cyc", CYC_O, 1'b0);
        chk_val("rst2_frm", FRM_CNT_O, 3'd0);
        @(posedge CLK_I); #1;
        RSTN_I = 1'b1;
        @(posedge CLK_I); #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
